// File: rtl/cu2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu2_pkg
// Purpose  : Shared definitions for the gen2 microsequencer: opcode values,
//            ALU operation codes, FSM state encoding and helpers that place
//            the fixed B-bus / C-bus slots above the NREG general registers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cu2_pkg;

  // Opcodes (IR[IR_W-1 -: 4])
  localparam logic [3:0] c_op_nop    = 4'h0;
  localparam logic [3:0] c_op_clac   = 4'h1;
  localparam logic [3:0] c_op_mvacr  = 4'h2;
  localparam logic [3:0] c_op_mvrac  = 4'h3;
  localparam logic [3:0] c_op_incr   = 4'h4;
  localparam logic [3:0] c_op_incar  = 4'h5;
  localparam logic [3:0] c_op_ldac   = 4'h6;
  localparam logic [3:0] c_op_stac   = 4'h7;
  localparam logic [3:0] c_op_add    = 4'h8;
  localparam logic [3:0] c_op_sub    = 4'h9;
  localparam logic [3:0] c_op_shift  = 4'hA;
  localparam logic [3:0] c_op_jpnz   = 4'hB;
  localparam logic [3:0] c_op_mvacar = 4'hC;
  localparam logic [3:0] c_op_mvactr = 4'hD;
  localparam logic [3:0] c_op_mvtrac = 4'hE;
  localparam logic [3:0] c_op_end    = 4'hF;

  // ALU operation codes; shifts are {1'b1, IR[1:0]}
  localparam logic [2:0] c_alu_clr  = 3'b000;
  localparam logic [2:0] c_alu_add  = 3'b001;
  localparam logic [2:0] c_alu_sub  = 3'b010;
  localparam logic [2:0] c_alu_pass = 3'b011;

  // Slot offsets above the general registers.
  // B-bus: TR, R, AC, MEM, IDLE.  C-bus: TR, R, AC, PC, AR.
  localparam int c_ofs_tr   = 0;
  localparam int c_ofs_ac   = 2;
  localparam int c_ofs_mem  = 3;
  localparam int c_ofs_idle = 4;
  localparam int c_ofs_pc   = 3;
  localparam int c_ofs_ar   = 4;

  typedef enum logic [4:0] {
    ST_RST    = 5'd0,
    ST_F1     = 5'd1,
    ST_F2     = 5'd2,
    ST_DEC    = 5'd3,
    ST_NOP    = 5'd4,
    ST_CLAC   = 5'd5,
    ST_MVACR  = 5'd6,
    ST_MVRAC  = 5'd7,
    ST_INCR   = 5'd8,
    ST_INCAR  = 5'd9,
    ST_LD1    = 5'd10,
    ST_LD2    = 5'd11,
    ST_ST1    = 5'd12,
    ST_ADD    = 5'd13,
    ST_SUB    = 5'd14,
    ST_SHIFT  = 5'd15,
    ST_JY     = 5'd16,
    ST_JN1    = 5'd17,
    ST_JN2    = 5'd18,
    ST_MVACAR = 5'd19,
    ST_MVACTR = 5'd20,
    ST_MVTRAC = 5'd21,
    ST_HALT   = 5'd22,
    ST_FLT    = 5'd23
  } state_e;

  // Bus slot index for a fixed source/destination placed above NREG registers
  function automatic int slot_idx(input int nreg, input int ofs);
    return nreg + ofs;
  endfunction

  // Opcodes whose operand field names a general register
  function automatic logic is_reg_op(input logic [3:0] op);
    return (op == c_op_mvacr) || (op == c_op_mvrac) || (op == c_op_incr) ||
           (op == c_op_add)   || (op == c_op_sub);
  endfunction

endpackage : cu2_pkg
`default_nettype wire

// File: rtl/cu_mem_timer.sv
`default_nettype none
// ============================================================================
// Module   : cu_mem_timer
// Purpose  : Wait-state timer for memory handshakes. Cleared whenever the
//            sequencer changes state, counts cycles spent waiting with
//            MEM_READY low, and flags expiry on the last allowed wait cycle.
// Ports    : clk_i    - clock (falling edge active, same as sequencer)
//            rst_i    - synchronous active-high reset
//            clear_i  - restart count (state transition)
//            count_i  - waiting and memory not ready this cycle
//            expire_o - this wait cycle reaches MEM_TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module cu_mem_timer #(
  parameter int  MEM_TIMEOUT = 15,
  localparam int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(negedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry is flagged while the final not-ready cycle is in progress so the
  // sequencer leaves the wait state on the very edge the limit is reached.
  assign expire_o = count_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule : cu_mem_timer
`default_nettype wire

// File: rtl/control_unit_gen2.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_gen2
// Purpose  : Gen2 microsequencer for the accumulator datapath. Fetches and
//            decodes IR, drives B-bus select, ALU op, one-hot C-bus write
//            enables and increment strobes. Memory accesses wait on
//            mem_ready_i with a timeout; illegal register operands and
//            timeouts lock into FAULT, END locks into FIN, until reset.
// Ports    : clk_i        - clock, state updates on the falling edge
//            rst_i        - synchronous active-high reset (falling edge)
//            flagz_i      - ALU zero flag (sampled in decode only)
//            ir_i         - instruction register
//            mem_ready_i  - memory completes current read/write
//            mem_rd_o / mem_wr_o / addr_pc_o / fetch_o - memory control
//            inc_pc_o / inc_ar_o / inc_r_o            - increment strobes
//            busb_sel_o   - B-bus source (Rn, TR, R, AC, MEM, IDLE)
//            alu_op_o     - ALU operation
//            cbus_we_o    - one-hot C-bus write {AR,PC,AC,R,TR,Rn..R1}
//            fin_o        - halted; fault_o - faulted (both sticky)
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_gen2
  import cu2_pkg::*;
#(
  parameter int  IR_W        = 8,
  parameter int  NREG        = 2,
  parameter int  MEM_TIMEOUT = 15,
  localparam int RIDX_W      = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int BSEL_W      = $clog2(NREG + 5),
  localparam int WE_W        = NREG + 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flagz_i,
  input  logic [IR_W-1:0]   ir_i,
  input  logic              mem_ready_i,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              addr_pc_o,
  output logic              fetch_o,
  output logic              inc_pc_o,
  output logic              inc_ar_o,
  output logic [NREG-1:0]   inc_r_o,
  output logic [BSEL_W-1:0] busb_sel_o,
  output logic [2:0]        alu_op_o,
  output logic [WE_W-1:0]   cbus_we_o,
  output logic              fin_o,
  output logic              fault_o
);

  localparam logic [BSEL_W-1:0] c_bsel_tr   = BSEL_W'(slot_idx(NREG, c_ofs_tr));
  localparam logic [BSEL_W-1:0] c_bsel_ac   = BSEL_W'(slot_idx(NREG, c_ofs_ac));
  localparam logic [BSEL_W-1:0] c_bsel_mem  = BSEL_W'(slot_idx(NREG, c_ofs_mem));
  localparam logic [BSEL_W-1:0] c_bsel_idle = BSEL_W'(slot_idx(NREG, c_ofs_idle));
  localparam int                c_we_tr     = slot_idx(NREG, c_ofs_tr);
  localparam int                c_we_ac     = slot_idx(NREG, c_ofs_ac);
  localparam int                c_we_pc     = slot_idx(NREG, c_ofs_pc);
  localparam int                c_we_ar     = slot_idx(NREG, c_ofs_ar);
  localparam logic [31:0]       c_nreg      = 32'(NREG);

  state_e state_q, state_d;

  logic [3:0]        w_opcode;
  logic [RIDX_W-1:0] w_ridx;
  logic [IR_W-5:0]   w_opnd;
  logic              w_opnd_bad;
  logic [NREG-1:0]   w_rsel;
  logic              w_wait;
  logic              w_expire;
  logic              w_clear;

  assign w_opcode = ir_i[IR_W-1 -: 4];
  assign w_ridx   = ir_i[RIDX_W-1:0];
  assign w_opnd   = ir_i[IR_W-5:0];

  // The whole operand field must name an existing register; checking only
  // the index bits would let e.g. idx 3 alias onto R2 when NREG=2.
  assign w_opnd_bad = (32'(w_opnd) >= c_nreg);

  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NREG; i++) begin
      w_rsel[i] = (w_ridx == RIDX_W'(i));
    end
  end

  assign w_wait = (state_q == ST_F1) || (state_q == ST_LD1) ||
                  (state_q == ST_ST1) || (state_q == ST_JN1);

  // Any state change restarts the timer, including wait-to-wait (ST1 -> F1)
  assign w_clear = (state_d != state_q);

  cu_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_clear),
    .count_i  (w_wait && !mem_ready_i),
    .expire_o (w_expire)
  );

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    addr_pc_o  = 1'b0;
    fetch_o    = 1'b0;
    inc_pc_o   = 1'b0;
    inc_ar_o   = 1'b0;
    inc_r_o    = '0;
    busb_sel_o = c_bsel_idle;
    alu_op_o   = c_alu_pass;
    cbus_we_o  = '0;
    fin_o      = 1'b0;
    fault_o    = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_F1;

      ST_F1: begin
        mem_rd_o  = 1'b1;
        addr_pc_o = 1'b1;
        // A ready on the expiry cycle still completes the access
        if (mem_ready_i)   state_d = ST_F2;
        else if (w_expire) state_d = ST_FLT;
      end

      ST_F2: begin
        fetch_o  = 1'b1;
        inc_pc_o = 1'b1;
        state_d  = ST_DEC;
      end

      ST_DEC: begin
        if (is_reg_op(w_opcode) && w_opnd_bad) begin
          state_d = ST_FLT;
        end else begin
          case (w_opcode)
            c_op_nop:    state_d = ST_NOP;
            c_op_clac:   state_d = ST_CLAC;
            c_op_mvacr:  state_d = ST_MVACR;
            c_op_mvrac:  state_d = ST_MVRAC;
            c_op_incr:   state_d = ST_INCR;
            c_op_incar:  state_d = ST_INCAR;
            c_op_ldac:   state_d = ST_LD1;
            c_op_stac:   state_d = ST_ST1;
            c_op_add:    state_d = ST_ADD;
            c_op_sub:    state_d = ST_SUB;
            c_op_shift:  state_d = ST_SHIFT;
            c_op_jpnz:   state_d = flagz_i ? ST_JY : ST_JN1;
            c_op_mvacar: state_d = ST_MVACAR;
            c_op_mvactr: state_d = ST_MVACTR;
            c_op_mvtrac: state_d = ST_MVTRAC;
            c_op_end:    state_d = ST_HALT;
          endcase
        end
      end

      ST_NOP: state_d = ST_F1;

      ST_CLAC: begin
        alu_op_o           = c_alu_clr;
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      ST_MVACR: begin
        busb_sel_o            = c_bsel_ac;
        cbus_we_o[NREG-1:0]   = w_rsel;
        state_d               = ST_F1;
      end

      ST_MVRAC: begin
        busb_sel_o         = BSEL_W'(w_ridx);
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      ST_INCR: begin
        inc_r_o = w_rsel;
        state_d = ST_F1;
      end

      ST_INCAR: begin
        inc_ar_o = 1'b1;
        state_d  = ST_F1;
      end

      ST_LD1: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i)   state_d = ST_LD2;
        else if (w_expire) state_d = ST_FLT;
      end

      ST_LD2: begin
        busb_sel_o         = c_bsel_mem;
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      ST_ST1: begin
        mem_wr_o = 1'b1;
        if (mem_ready_i)   state_d = ST_F1;
        else if (w_expire) state_d = ST_FLT;
      end

      ST_ADD, ST_SUB: begin
        busb_sel_o         = BSEL_W'(w_ridx);
        alu_op_o           = (state_q == ST_ADD) ? c_alu_add : c_alu_sub;
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      ST_SHIFT: begin
        // IR[1:0]: 00 x2, 01 x4, 10 /2, 11 /4 map straight onto 1xx codes
        alu_op_o           = {1'b1, ir_i[1:0]};
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      // Zero flag set: skip the jump target operand word
      ST_JY: begin
        inc_pc_o = 1'b1;
        state_d  = ST_F1;
      end

      ST_JN1: begin
        mem_rd_o  = 1'b1;
        addr_pc_o = 1'b1;
        if (mem_ready_i)   state_d = ST_JN2;
        else if (w_expire) state_d = ST_FLT;
      end

      ST_JN2: begin
        busb_sel_o         = c_bsel_mem;
        cbus_we_o[c_we_pc] = 1'b1;
        state_d            = ST_F1;
      end

      ST_MVACAR: begin
        busb_sel_o         = c_bsel_ac;
        cbus_we_o[c_we_ar] = 1'b1;
        state_d            = ST_F1;
      end

      ST_MVACTR: begin
        busb_sel_o         = c_bsel_ac;
        cbus_we_o[c_we_tr] = 1'b1;
        state_d            = ST_F1;
      end

      ST_MVTRAC: begin
        busb_sel_o         = c_bsel_tr;
        cbus_we_o[c_we_ac] = 1'b1;
        state_d            = ST_F1;
      end

      ST_HALT: fin_o = 1'b1;

      ST_FLT: fault_o = 1'b1;

      default: state_d = ST_FLT;
    endcase
  end

endmodule : control_unit_gen2
`default_nettype wire

// File: tb/tb_control_unit_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_gen2
// Purpose  : Self-checking bench for control_unit_gen2 (default parameters).
//            An instruction-level model expands each instruction, together
//            with chosen memory wait lengths, into the expected per-cycle
//            output vectors and the inputs to apply in each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit_gen2;

  localparam int NREG    = 2;
  localparam int TIMEOUT = 15;
  // Bus slots above the two general registers
  localparam int B_TR = 2, B_AC = 4, B_MEM = 5, B_IDLE = 6;
  localparam int W_TR = 2, W_AC = 4, W_PC = 5, W_AR = 6;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_pc;
    logic       fetch;
    logic       inc_pc;
    logic       inc_ar;
    logic [1:0] inc_r;
    logic [2:0] busb;
    logic [2:0] alu;
    logic [6:0] cbus;
    logic       fin;
    logic       fault;
  } outv_t;

  typedef struct {
    outv_t      exp;
    bit         rdy;
    logic [7:0] ir;
    bit         fz;
  } step_t;

  logic       clk, rst, flagz, mem_ready;
  logic [7:0] ir;
  logic       mem_rd, mem_wr, addr_pc, fetch, inc_pc, inc_ar, fin, fault;
  logic [1:0] inc_r;
  logic [2:0] busb, alu;
  logic [6:0] cbus;
  outv_t      outs;

  int    n_checks = 0;
  int    n_errors = 0;
  step_t steps[$];

  control_unit_gen2 #(.IR_W(8), .NREG(NREG), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flagz_i     (flagz),
    .ir_i        (ir),
    .mem_ready_i (mem_ready),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .addr_pc_o   (addr_pc),
    .fetch_o     (fetch),
    .inc_pc_o    (inc_pc),
    .inc_ar_o    (inc_ar),
    .inc_r_o     (inc_r),
    .busb_sel_o  (busb),
    .alu_op_o    (alu),
    .cbus_we_o   (cbus),
    .fin_o       (fin),
    .fault_o     (fault)
  );

  assign outs = {mem_rd, mem_wr, addr_pc, fetch, inc_pc, inc_ar, inc_r,
                 busb, alu, cbus, fin, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outv_t v_idle();
    outv_t v;
    v      = '0;
    v.busb = 3'(B_IDLE);
    v.alu  = 3'b011;
    return v;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input outv_t e, input bit r, input logic [7:0] i, input bit f);
    step_t s;
    s.exp = e; s.rdy = r; s.ir = i; s.fz = f;
    steps.push_back(s);
  endtask

  // A wait of d not-ready cycles followed by one ready cycle, or a timeout
  task automatic push_wait(input outv_t v, input int d, input logic [7:0] irv,
                           input bit garbage_ir, output bit tmo);
    int n;
    n = (d < TIMEOUT) ? d : TIMEOUT;
    for (int k = 0; k < n; k++)
      push(v, 1'b0, garbage_ir ? 8'($urandom) : irv, rbit());
    tmo = (d >= TIMEOUT);
    if (!tmo) push(v, 1'b1, garbage_ir ? 8'($urandom) : irv, rbit());
  endtask

  // Expand one instruction. term: 0 back to fetch, 1 fault, 2 halt.
  task automatic add_instr(input logic [7:0] irv, input bit fz, input int dfetch,
                           input int dexec, output int term);
    outv_t      v;
    bit         tmo;
    logic [3:0] op;
    int         idx;
    op   = irv[7:4];
    idx  = int'(irv[0]);
    term = 0;
    v = v_idle(); v.mem_rd = 1'b1; v.addr_pc = 1'b1;
    push_wait(v, dfetch, irv, 1'b1, tmo);
    if (tmo) begin term = 1; return; end
    v = v_idle(); v.fetch = 1'b1; v.inc_pc = 1'b1;
    push(v, rbit(), 8'($urandom), rbit());
    push(v_idle(), rbit(), irv, fz);
    if ((op inside {4'h2, 4'h3, 4'h4, 4'h8, 4'h9}) && (int'(irv[3:0]) >= NREG)) begin
      term = 1; return;
    end
    v = v_idle();
    case (op)
      4'h0: ;
      4'h1: begin v.alu = 3'b000; v.cbus[W_AC] = 1'b1; end
      4'h2: begin v.busb = 3'(B_AC); v.cbus[idx] = 1'b1; end
      4'h3: begin v.busb = 3'(idx); v.cbus[W_AC] = 1'b1; end
      4'h4: v.inc_r[idx] = 1'b1;
      4'h5: v.inc_ar = 1'b1;
      4'h6: begin
        v.mem_rd = 1'b1;
        push_wait(v, dexec, irv, 1'b0, tmo);
        if (tmo) begin term = 1; return; end
        v = v_idle(); v.busb = 3'(B_MEM); v.cbus[W_AC] = 1'b1;
      end
      4'h7: begin
        v.mem_wr = 1'b1;
        push_wait(v, dexec, irv, 1'b0, tmo);
        if (tmo) term = 1;
        return;
      end
      4'h8: begin v.busb = 3'(idx); v.alu = 3'b001; v.cbus[W_AC] = 1'b1; end
      4'h9: begin v.busb = 3'(idx); v.alu = 3'b010; v.cbus[W_AC] = 1'b1; end
      4'hA: begin v.alu = {1'b1, irv[1:0]}; v.cbus[W_AC] = 1'b1; end
      4'hB: begin
        if (fz) begin
          v.inc_pc = 1'b1;
        end else begin
          v.mem_rd = 1'b1; v.addr_pc = 1'b1;
          push_wait(v, dexec, irv, 1'b0, tmo);
          if (tmo) begin term = 1; return; end
          v = v_idle(); v.busb = 3'(B_MEM); v.cbus[W_PC] = 1'b1;
        end
      end
      4'hC: begin v.busb = 3'(B_AC); v.cbus[W_AR] = 1'b1; end
      4'hD: begin v.busb = 3'(B_AC); v.cbus[W_TR] = 1'b1; end
      4'hE: begin v.busb = 3'(B_TR); v.cbus[W_AC] = 1'b1; end
      default: begin term = 2; return; end
    endcase
    push(v, rbit(), irv, rbit());
  endtask

  task automatic push_terminal(input int term, input int n);
    outv_t v;
    v = v_idle();
    if (term == 1) v.fault = 1'b1; else v.fin = 1'b1;
    for (int k = 0; k < n; k++) push(v, rbit(), 8'($urandom), rbit());
  endtask

  task automatic apply_reset();
    rst = 1'b1; mem_ready = 1'b1; ir = 8'h00; flagz = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int term, pcs;
    rst = 1'b1; mem_ready = 1'b1; ir = 8'h00; flagz = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      if (c > 0) begin
        n_checks++;
        if (outs !== v_idle()) begin
          n_errors++;
          $display("FAIL reset_idle cyc %0d: got %h want %h", c, outs, v_idle());
        end
      end
    end
    rst = 1'b0;
    steps.delete();
    for (int k = 0; k < 3; k++) add_instr(8'h00, 1'b0, 0, 0, term);
    pcs = 0;
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== steps[i].exp) begin
        n_errors++;
        $display("FAIL nop_loop step %0d: got %h want %h", i, outs, steps[i].exp);
      end
      pcs += int'(inc_pc);
      mem_ready = 1'b1; ir = 8'h00; flagz = steps[i].fz;
    end
    n_checks++;
    if (pcs !== 3) begin
      n_errors++;
      $display("FAIL nop_inc_pc_count: got %0d want 3", pcs);
    end
  endtask

  // Single instruction scenario with optional terminal hold and reset
  task automatic test_single(input string name, input logic [7:0] irv, input bit fz,
                             input int dfetch, input int dexec);
    int term;
    apply_reset();
    steps.delete();
    add_instr(irv, fz, dfetch, dexec, term);
    if (term != 0) push_terminal(term, 6);
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== steps[i].exp) begin
        n_errors++;
        $display("FAIL %s step %0d: got %h want %h", name, i, outs, steps[i].exp);
      end
      mem_ready = steps[i].rdy; ir = steps[i].ir; flagz = steps[i].fz;
    end
  endtask

  // Terminal state is left only by reset, and execution restarts at fetch
  task automatic test_halt_restart();
    int term;
    test_single("halt", 8'hF0, 1'b0, 0, 0);
    apply_reset();
    steps.delete();
    add_instr(8'h00, 1'b0, 0, 0, term);
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== steps[i].exp) begin
        n_errors++;
        $display("FAIL halt_restart step %0d: got %h want %h", i, outs, steps[i].exp);
      end
      mem_ready = steps[i].rdy; ir = steps[i].ir; flagz = steps[i].fz;
    end
  endtask

  // STAC wait immediately followed by a slow fetch: each wait gets its own budget
  task automatic test_back_to_back();
    int term;
    apply_reset();
    steps.delete();
    add_instr(8'h70, 1'b0, 0, 10, term);
    add_instr(8'h81, 1'b0, 10, 0, term);
    add_instr(8'h60, 1'b0, 14, 14, term);
    for (int i = 0; i < steps.size(); i++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== steps[i].exp) begin
        n_errors++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, outs, steps[i].exp);
      end
      mem_ready = steps[i].rdy; ir = steps[i].ir; flagz = steps[i].fz;
    end
  endtask

  // Reset during an LDAC wait: idle next cycle, no AC write, fetch after release
  task automatic test_reset_midwait();
    int    term;
    outv_t v;
    apply_reset();
    steps.delete();
    add_instr(8'h60, 1'b0, 0, 15, term);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== steps[i].exp) begin
        n_errors++;
        $display("FAIL midwait step %0d: got %h want %h", i, outs, steps[i].exp);
      end
      mem_ready = steps[i].rdy; ir = steps[i].ir; flagz = steps[i].fz;
    end
    rst = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      n_checks++;
      if (outs !== v_idle()) begin
        n_errors++;
        $display("FAIL midwait_reset cyc %0d: got %h want %h", c, outs, v_idle());
      end
    end
    rst = 1'b0;
    @(posedge clk);
    v = v_idle(); v.mem_rd = 1'b1; v.addr_pc = 1'b1;
    n_checks++;
    if (outs !== v) begin
      n_errors++;
      $display("FAIL midwait_refetch: got %h want %h", outs, v);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 8)  return int'($urandom_range(0, 3));
    if (r == 8) return TIMEOUT - 1;
    if (r == 9) return TIMEOUT;
    return 0;
  endfunction

  task automatic test_random(input int n_instr);
    int term;
    apply_reset();
    for (int n = 0; n < n_instr; n++) begin
      steps.delete();
      add_instr(8'($urandom), rbit(), pick_delay(), pick_delay(), term);
      if (term != 0) push_terminal(term, 3);
      for (int i = 0; i < steps.size(); i++) begin
        @(posedge clk);
        n_checks++;
        if (outs !== steps[i].exp) begin
          n_errors++;
          $display("FAIL random instr %0d step %0d: got %h want %h", n, i, outs, steps[i].exp);
        end
        mem_ready = steps[i].rdy; ir = steps[i].ir; flagz = steps[i].fz;
      end
      if (term != 0) apply_reset();
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; ir = 8'h00; flagz = 1'b0;
    test_reset();
    test_single("add_r2",       8'h81, 1'b0, 0, 0);
    test_single("sub_r1",       8'h90, 1'b1, 2, 0);
    test_single("illegal_idx",  8'h23, 1'b0, 0, 0);
    test_single("ldac_wait4",   8'h60, 1'b0, 0, 4);
    test_single("ldac_timeout", 8'h60, 1'b0, 0, 15);
    test_single("fetch_tmo",    8'h00, 1'b0, 15, 0);
    test_single("jpnz_z1",      8'hB0, 1'b1, 0, 0);
    test_single("jpnz_z0",      8'hB0, 1'b0, 1, 3);
    test_single("shift_div4",   8'hA3, 1'b0, 0, 0);
    test_single("mvtrac",       8'hE0, 1'b0, 0, 0);
    test_halt_restart();
    test_back_to_back();
    test_reset_midwait();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_control_unit_gen2
`default_nettype wire
